sd_cmd_ctrl: RTL
================

Name: sd_cmd_ctrl

Overview:
- SD-bus command-line controller. Sequences one shared sd_crc_7 datapath through a full command transaction.
- Transaction: serialise a 48-bit host command onto CMD, append the CRC7, then optionally capture and CRC-check a 48-bit card response.
- Sits between the host register interface and the CMD pad. The CRC7 unit is external and is driven only through the CRC_* ports.

Parameters:
RESP_TIMEOUT, 64, max CLK cycles to wait for a response start bit after the command end bit (NCR window)
TIMEOUT_W, 8, width of timeout counter; must satisfy 2^TIMEOUT_W > RESP_TIMEOUT

Ports:
CLK  input  1  bus clock, all logic on rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  one-cycle request; accepted only when BUSY=0
CMD_INDEX  input  6  command index, sampled on accepted START
CMD_ARG  input  32  command argument, sampled on accepted START
RESP_EN  input  1  1 = expect a 48-bit response, sampled on accepted START
BUSY  output  1  high from the cycle after START acceptance until DONE
DONE  output  1  one-cycle completion pulse
RESP_INDEX  output  6  captured response bits [45:40]
RESP_ARG  output  32  captured response bits [39:8]
CRC_ERR  output  1  response CRC7 mismatch or end bit = 0; valid with DONE
TIMEOUT  output  1  no response start bit within RESP_TIMEOUT; valid with DONE
CMD_OUT  output  1  command line drive value
CMD_OE  output  1  command line output enable
CMD_IN  input  1  command line sampled value
CRC_BITVAL  output  1  bit fed to sd_crc_7
CRC_EN  output  1  sd_crc_7 Enable
CRC_CLR  output  1  sd_crc_7 reset (active-high), one-cycle pulse
CRC_VAL  input  7  sd_crc_7 CRC output

Behaviour:
- Reset (RST_N=0, any time, including mid-transaction), immediately:
  - state=IDLE; BUSY=0, DONE=0, CMD_OE=0, CMD_OUT=1, CRC_EN=0, CRC_CLR=0.
  - RESP_INDEX=0, RESP_ARG=0, CRC_ERR=0, TIMEOUT=0.
  - Partial frame is abandoned; no DONE is generated.
- States: IDLE -> CLR_TX -> TX_DATA -> TX_CRC -> TX_END -> (RESP_EN ? RX_WAIT : FIN) ; RX_WAIT -> RX_DATA -> RX_CRC -> RX_END -> FIN -> IDLE.
- IDLE:
  - START=1 latches the frame: {0, 1, CMD_INDEX, CMD_ARG}, 40 bits, MSB first.
  - START also latches RESP_EN, clears CRC_ERR/TIMEOUT, and moves to CLR_TX.
  - START while BUSY=1 is ignored; no state or output change.
- CLR_TX (1 cycle): CRC_CLR=1, CMD_OE=1, CMD_OUT=1.
- TX_DATA (40 cycles, k=0..39):
  - CMD_OUT = frame bit k; CRC_BITVAL = the same bit; CRC_EN=1.
  - CRC absorbs bit k at the end of cycle k.
- TX_CRC (7 cycles, j=0..6): CRC_EN=0; CMD_OUT = CRC_VAL[6-j], combinational from the stable CRC register.
- TX_END (1 cycle): CMD_OUT=1.
  - RESP_EN=0: go to FIN.
  - RESP_EN=1: pulse CRC_CLR, release line (CMD_OE=0 from the next cycle), go to RX_WAIT.
- Command line timing: no idle cycles inside the 48 command bits; CMD_OE high for exactly 49 cycles (CLR_TX + 48 bits).
- RX_WAIT:
  - Counts cycles, sampling CMD_IN each cycle.
  - First CMD_IN=0 is the start bit: feed it to the CRC (CRC_EN=1, CRC_BITVAL=0) and go to RX_DATA.
  - If the count reaches RESP_TIMEOUT with no 0 seen: TIMEOUT=1, go to FIN.
  - A start bit on the same cycle the count expires counts as a response, not a timeout.
- RX_DATA (39 cycles):
  - Bits 1..39 shift into a 39-bit capture register and into the CRC (CRC_EN=1).
  - RESP_INDEX / RESP_ARG update at the end of RX_DATA.
- RX_CRC (7 cycles): CRC_EN=0; compare CMD_IN against CRC_VAL[6-j]; any mismatch sets CRC_ERR.
- RX_END (1 cycle): CMD_IN=0 sets CRC_ERR.
- FIN (1 cycle): DONE=1, BUSY=0 from the next cycle; result flags held until the next accepted START.
- Latency, RESP_EN=0: DONE occurs 50 cycles after the START cycle.

Test Plan:
- CMD_INDEX=0, CMD_ARG=0, RESP_EN=0 -> CMD_OUT bits 0x40_0000_0000 then CRC 0x4A, end 1 (byte 0x95); DONE 50 cycles after START; CMD_OE high 49 cycles.
- CMD_INDEX=17, CMD_ARG=0, RESP_EN=0 -> CRC bits 0x2A (last byte 0x55).
- CMD_INDEX=8, CMD_ARG=0x1AA, RESP_EN=1 -> TX CRC 0x43 (byte 0x87). Bench drives 0x08_0000_01AA_13 after 5 idle cycles -> RESP_INDEX=8, RESP_ARG=0x000001AA, CRC_ERR=0, TIMEOUT=0.
- Same as the previous scenario, but response CRC byte is 0x15 or end bit is 0 -> CRC_ERR=1, DONE pulses, captured fields still updated.
- RESP_EN=1, CMD_IN held 1 -> TIMEOUT=1, DONE exactly RESP_TIMEOUT cycles after RX_WAIT entry.
- START pulsed during TX_DATA -> ignored. RST_N low at bit 20 -> CMD_OE=0, CMD_OUT=1, BUSY=0 immediately, no DONE. New START after release -> correct full frame.

Source files
------------

// File: rtl/sd_cmd_ctrl_if.sv
// SD command-line controller bus bundle: host request/result signals,
// CMD pad drive/sample and the external sd_crc_7 control/result lines.
interface sd_cmd_ctrl_if;
   // host side
   logic        START;
   logic [5:0]  CMD_INDEX;
   logic [31:0] CMD_ARG;
   logic        RESP_EN;
   logic        BUSY;
   logic        DONE;
   logic [5:0]  RESP_INDEX;
   logic [31:0] RESP_ARG;
   logic        CRC_ERR;
   logic        TIMEOUT;
   // CMD pad
   logic        CMD_OUT;
   logic        CMD_OE;
   logic        CMD_IN;
   // external CRC7 unit
   logic        CRC_BITVAL;
   logic        CRC_EN;
   logic        CRC_CLR;
   logic [6:0]  CRC_VAL;

   // controller view
   modport slave (
      input  START, CMD_INDEX, CMD_ARG, RESP_EN, CMD_IN, CRC_VAL,
      output BUSY, DONE, RESP_INDEX, RESP_ARG, CRC_ERR, TIMEOUT,
      output CMD_OUT, CMD_OE, CRC_BITVAL, CRC_EN, CRC_CLR
   );

   // host / pad / CRC-unit view
   modport master (
      output START, CMD_INDEX, CMD_ARG, RESP_EN, CMD_IN, CRC_VAL,
      input  BUSY, DONE, RESP_INDEX, RESP_ARG, CRC_ERR, TIMEOUT,
      input  CMD_OUT, CMD_OE, CRC_BITVAL, CRC_EN, CRC_CLR
   );
endinterface

// File: rtl/sd_cmd_ctrl.sv
// SD-bus command-line controller. Serialises a 48-bit command (40 data bits
// plus CRC7 and end bit) and optionally captures and checks a 48-bit response,
// sequencing a single external sd_crc_7 unit for both directions.
module sd_cmd_ctrl #(
   parameter int RESP_TIMEOUT = 64,
   parameter int TIMEOUT_W    = 8
) (
   input  logic          CLK,
   input  logic          RST_N,
   sd_cmd_ctrl_if.slave  bus
);

   typedef enum logic [3:0] {
      S_IDLE, S_CLR_TX, S_TX_DATA, S_TX_CRC, S_TX_END,
      S_RX_WAIT, S_RX_DATA, S_RX_CRC, S_RX_END, S_FIN
   } state_t;

   state_t                 state_q, state_d;
   logic [5:0]             cnt_q, cnt_d;
   logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
   logic [39:0]            frame_q, frame_d;
   logic                   resp_en_q, resp_en_d;
   // response bits 2..39; the transmission bit shifts off the top
   logic [37:0]            cap_q, cap_d;
   logic [5:0]             resp_index_q, resp_index_d;
   logic [31:0]            resp_arg_q, resp_arg_d;
   logic                   crc_err_q, crc_err_d;
   logic                   timeout_q, timeout_d;

   logic cmd_out_s, cmd_oe_s, crc_en_s, crc_bitval_s, crc_clr_s, done_s;

   // Next-state, datapath updates and Moore/Mealy line and CRC controls
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      tmo_d        = tmo_q;
      frame_d      = frame_q;
      resp_en_d    = resp_en_q;
      cap_d        = cap_q;
      resp_index_d = resp_index_q;
      resp_arg_d   = resp_arg_q;
      crc_err_d    = crc_err_q;
      timeout_d    = timeout_q;
      cmd_out_s    = 1'b1;
      cmd_oe_s     = 1'b0;
      crc_en_s     = 1'b0;
      crc_bitval_s = 1'b0;
      crc_clr_s    = 1'b0;
      done_s       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               frame_d   = {1'b0, 1'b1, bus.CMD_INDEX, bus.CMD_ARG};
               resp_en_d = bus.RESP_EN;
               crc_err_d = 1'b0;
               timeout_d = 1'b0;
               state_d   = S_CLR_TX;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_CLR_TX: begin
            crc_clr_s = 1'b1;
            cmd_oe_s  = 1'b1;
            cnt_d     = 6'd0;
            state_d   = S_TX_DATA;
         end
         S_TX_DATA: begin
            cmd_oe_s     = 1'b1;
            cmd_out_s    = frame_q[39];
            crc_bitval_s = frame_q[39];
            crc_en_s     = 1'b1;
            frame_d      = {frame_q[38:0], 1'b0};
            if (cnt_q == 6'd39) begin
               cnt_d   = 6'd0;
               state_d = S_TX_CRC;
            end else begin
               cnt_d   = cnt_q + 6'd1;
            end
         end
         S_TX_CRC: begin
            // CRC register is frozen here, so the line can be driven straight from it
            cmd_oe_s  = 1'b1;
            cmd_out_s = bus.CRC_VAL[3'd6 - cnt_q[2:0]];
            if (cnt_q == 6'd6) begin
               cnt_d   = 6'd0;
               state_d = S_TX_END;
            end else begin
               cnt_d   = cnt_q + 6'd1;
            end
         end
         S_TX_END: begin
            cmd_oe_s  = 1'b1;
            cmd_out_s = 1'b1;
            if (resp_en_q) begin
               crc_clr_s = 1'b1;
               tmo_d     = '0;
               state_d   = S_RX_WAIT;
            end else begin
               state_d   = S_FIN;
            end
         end
         S_RX_WAIT: begin
            // a start bit wins over an expiring count
            if (!bus.CMD_IN) begin
               crc_en_s     = 1'b1;
               crc_bitval_s = 1'b0;
               cnt_d        = 6'd0;
               state_d      = S_RX_DATA;
            end else if (tmo_q == TIMEOUT_W'(RESP_TIMEOUT - 1)) begin
               timeout_d    = 1'b1;
               state_d      = S_FIN;
            end else begin
               tmo_d        = tmo_q + TIMEOUT_W'(1);
            end
         end
         S_RX_DATA: begin
            crc_en_s     = 1'b1;
            crc_bitval_s = bus.CMD_IN;
            cap_d        = {cap_q[36:0], bus.CMD_IN};
            if (cnt_q == 6'd38) begin
               resp_index_d = cap_d[37:32];
               resp_arg_d   = cap_d[31:0];
               cnt_d        = 6'd0;
               state_d      = S_RX_CRC;
            end else begin
               cnt_d        = cnt_q + 6'd1;
            end
         end
         S_RX_CRC: begin
            if (bus.CMD_IN != bus.CRC_VAL[3'd6 - cnt_q[2:0]]) begin
               crc_err_d = 1'b1;
            end else begin
               crc_err_d = crc_err_q;
            end
            if (cnt_q == 6'd6) begin
               cnt_d   = 6'd0;
               state_d = S_RX_END;
            end else begin
               cnt_d   = cnt_q + 6'd1;
            end
         end
         S_RX_END: begin
            if (!bus.CMD_IN) begin
               crc_err_d = 1'b1;
            end else begin
               crc_err_d = crc_err_q;
            end
            state_d = S_FIN;
         end
         S_FIN: begin
            done_s  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any partial frame
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= S_IDLE;
         cnt_q        <= 6'd0;
         tmo_q        <= '0;
         frame_q      <= 40'd0;
         resp_en_q    <= 1'b0;
         cap_q        <= 38'd0;
         resp_index_q <= 6'd0;
         resp_arg_q   <= 32'd0;
         crc_err_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         tmo_q        <= tmo_d;
         frame_q      <= frame_d;
         resp_en_q    <= resp_en_d;
         cap_q        <= cap_d;
         resp_index_q <= resp_index_d;
         resp_arg_q   <= resp_arg_d;
         crc_err_q    <= crc_err_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.BUSY       = (state_q != S_IDLE);
   assign bus.DONE       = done_s;
   assign bus.RESP_INDEX = resp_index_q;
   assign bus.RESP_ARG   = resp_arg_q;
   assign bus.CRC_ERR    = crc_err_q;
   assign bus.TIMEOUT    = timeout_q;
   assign bus.CMD_OUT    = cmd_out_s;
   assign bus.CMD_OE     = cmd_oe_s;
   assign bus.CRC_BITVAL = crc_bitval_s;
   assign bus.CRC_EN     = crc_en_s;
   assign bus.CRC_CLR    = crc_clr_s;

endmodule
